// File: rtl/rng_draw_arbiter.sv
// Round-robin arbiter sharing one 4-bit Fibonacci LFSR (x^4+x^3+1) among N_REQ
// requesters; each grant returns one unbiased digit 0..9 by rejection sampling.
module rng_draw_arbiter #(
  parameter int          N_REQ = 4,
  parameter logic [3:0]  SEED  = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [3:0]       seed_in,
  output logic             busy,
  output logic             rsp_valid,
  output logic [N_REQ-1:0] rsp_gnt,
  output logic [3:0]       rsp_digit,
  output logic [7:0]       rej_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [3:0]    digit_q, digit_d;
  logic [7:0]    rej_q, rej_d;

  logic [3:0]    nxt;
  logic          found;
  logic [PW-1:0] pick;
  int unsigned   idx;

  assign nxt = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  // First set request at or after rr_q, scanning circularly without a modulo.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == idx)) begin
          found = 1'b1;
          pick  = PW'(j);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    digit_d = digit_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_in == 4'd0) ? SEED : seed_in;
        end else if (found) begin
          owner_d = pick;
          state_d = DRAW;
        end
      end
      DRAW: begin
        lfsr_d = nxt;
        if ((nxt != 4'd0) && (nxt <= 4'd10)) begin
          digit_d = nxt - 4'd1;
          state_d = DONE;
        end else if (rej_q != 8'hFF) begin
          rej_d = rej_q + 8'd1;
        end
      end
      DONE: begin
        if (owner_q == PW'(N_REQ - 1)) rr_d = '0;
        else                           rr_d = owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      owner_q <= '0;
      rr_q    <= '0;
      digit_q <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      digit_q <= digit_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    rsp_gnt = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      rsp_gnt[j] = (state_q == DONE) && (owner_q == PW'(j));
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_digit = digit_q;
  assign rej_cnt   = rej_q;

endmodule

// File: tb/tb_rng_draw_arbiter.sv
// Directed bench for rng_draw_arbiter: table of per-response expectations plus
// hand-written sequences for seeding, withdrawal, mid-draw reset and saturation.
module tb_rng_draw_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [3:0] seed_in;
  logic       busy;
  logic       rsp_valid;
  logic [3:0] rsp_gnt;
  logic [3:0] rsp_digit;
  logic [7:0] rej_cnt;

  int checks = 0;
  int errors = 0;

  rng_draw_arbiter #(.N_REQ(4), .SEED(4'b1011)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_gnt   (rsp_gnt),
    .rsp_digit (rsp_digit),
    .rej_cnt   (rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_first;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] digit;
    int         cyc;
    logic [7:0] rej;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'b0000;
    seed_load = 1'b0;
    seed_in   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts falling edges until rsp_valid is seen, bounded by maxc.
  task automatic wait_rsp(input int maxc, output int cyc, output logic ok);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < maxc);
    ok = rsp_valid;
  endtask

  int   cyc;
  logic ok;
  int   viol;
  int   tmo;

  initial begin
    // Single requester: digits 6,7,0,1,3,8,2,5,9,4,6
    vecs[0]  = '{1'b1, 4'b0001, 4'b0001, 4'd6, 2, 8'd0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 4'd7, 6, 8'd3};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 4'd0, 3, 8'd3};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001, 4'd1, 3, 8'd3};
    vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 4'd3, 3, 8'd3};
    vecs[5]  = '{1'b0, 4'b0001, 4'b0001, 4'd8, 3, 8'd3};
    vecs[6]  = '{1'b0, 4'b0001, 4'b0001, 4'd2, 3, 8'd3};
    vecs[7]  = '{1'b0, 4'b0001, 4'b0001, 4'd5, 3, 8'd3};
    vecs[8]  = '{1'b0, 4'b0001, 4'b0001, 4'd9, 4, 8'd4};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0001, 4'd4, 3, 8'd4};
    vecs[10] = '{1'b0, 4'b0001, 4'b0001, 4'd6, 4, 8'd5};
    // All four held: round-robin grants
    vecs[11] = '{1'b1, 4'b1111, 4'b0001, 4'd6, 2, 8'd0};
    vecs[12] = '{1'b0, 4'b1111, 4'b0010, 4'd7, 6, 8'd3};
    vecs[13] = '{1'b0, 4'b1111, 4'b0100, 4'd0, 3, 8'd3};
    vecs[14] = '{1'b0, 4'b1111, 4'b1000, 4'd1, 3, 8'd3};
    vecs[15] = '{1'b0, 4'b1111, 4'b0001, 4'd3, 3, 8'd3};

    do_reset();
    chk("rst_busy",   int'(busy), 0);
    chk("rst_valid",  int'(rsp_valid), 0);
    chk("rst_gnt",    int'(rsp_gnt), 0);
    chk("rst_digit",  int'(rsp_digit), 0);
    chk("rst_rejcnt", int'(rej_cnt), 0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst_first) do_reset();
      req = vecs[i].req;
      wait_rsp(12, cyc, ok);
      chk($sformatf("v%0d_valid", i), int'(ok), 1);
      chk($sformatf("v%0d_cyc", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_gnt", i), int'(rsp_gnt), int'(vecs[i].gnt));
      chk($sformatf("v%0d_digit", i), int'(rsp_digit), int'(vecs[i].digit));
      chk($sformatf("v%0d_rej", i), int'(rej_cnt), int'(vecs[i].rej));
    end

    // Seeding in IDLE: zero seed maps to SEED, 1101 yields 10 -> digit 9
    do_reset();
    req = 4'b0001;
    wait_rsp(12, cyc, ok);
    chk("sd0_first_digit", int'(rsp_digit), 6);
    req = 4'b0000;
    @(negedge clk);
    seed_load = 1'b1; seed_in = 4'd0;
    @(negedge clk);
    seed_load = 1'b0; req = 4'b0001;
    wait_rsp(12, cyc, ok);
    chk("sd0_cyc", cyc, 2);
    chk("sd0_digit", int'(rsp_digit), 6);
    req = 4'b0000;
    @(negedge clk);
    seed_load = 1'b1; seed_in = 4'b1101;
    @(negedge clk);
    seed_load = 1'b0; req = 4'b0001;
    wait_rsp(12, cyc, ok);
    chk("sd13_digit", int'(rsp_digit), 9);
    chk("sd13_rej", int'(rej_cnt), 0);
    req = 4'b0000;

    // seed_load while busy is ignored
    do_reset();
    req = 4'b0001;
    wait_rsp(12, cyc, ok);
    chk("sb_first", int'(rsp_digit), 6);
    repeat (2) @(negedge clk);
    chk("sb_busy", int'(busy), 1);
    seed_load = 1'b1; seed_in = 4'b1101;
    @(negedge clk);
    seed_load = 1'b0;
    wait_rsp(12, cyc, ok);
    chk("sb_cyc", cyc, 3);
    chk("sb_digit2", int'(rsp_digit), 7);
    wait_rsp(12, cyc, ok);
    chk("sb_digit3", int'(rsp_digit), 0);
    req = 4'b0000;

    // Request withdrawn after grant; others wait for IDLE
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    chk("wd_busy", int'(busy), 1);
    req = 4'b1110;
    wait_rsp(12, cyc, ok);
    chk("wd_cyc", cyc, 1);
    chk("wd_gnt", int'(rsp_gnt), 4'b0001);
    chk("wd_digit", int'(rsp_digit), 6);
    wait_rsp(12, cyc, ok);
    chk("wd_next_cyc", cyc, 6);
    chk("wd_next_gnt", int'(rsp_gnt), 4'b0010);
    chk("wd_next_digit", int'(rsp_digit), 7);
    req = 4'b0000;

    // Reset mid-draw
    do_reset();
    req = 4'b0001;
    wait_rsp(12, cyc, ok);
    repeat (3) @(negedge clk);
    chk("mr_pre_rej", int'(rej_cnt), 1);
    chk("mr_pre_busy", int'(busy), 1);
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    chk("mr_busy", int'(busy), 0);
    chk("mr_valid", int'(rsp_valid), 0);
    chk("mr_rej", int'(rej_cnt), 0);
    rst = 1'b0; req = 4'b0001;
    wait_rsp(12, cyc, ok);
    chk("mr_cyc", cyc, 2);
    chk("mr_digit", int'(rsp_digit), 6);

    // Long run: rej_cnt saturates, digits stay in range
    do_reset();
    req  = 4'b0001;
    viol = 0;
    tmo  = 0;
    for (int n = 0; n < 600; n++) begin
      wait_rsp(12, cyc, ok);
      if (!ok) tmo++;
      if (rsp_digit > 4'd9) viol++;
    end
    chk("sat_timeouts", tmo, 0);
    chk("sat_digit_range", viol, 0);
    chk("sat_rejcnt", int'(rej_cnt), 255);
    req = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
